// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the digit-count helper for a W-bit input.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Smallest digit count n with 10^n > 2^w - 1.
  function automatic int ndig_for(input int w);
    logic [127:0] lim;
    logic [127:0] p;
    int           n;
    lim = (128'd1 << w) - 128'd1;
    p   = 128'd1;
    n   = 0;
    while (p <= lim) begin
      p = p * 128'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD digit that is 5 or more.
// Ports: d = digit in, q = adjusted digit out (combinational).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
// Ports: Clk/Rst (sync high), Start+Bin in; Busy, Done pulse, Bcd, Neg out.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int W      = 32,
  parameter int NDIG   = ndig_for(W),
  parameter bit SIGNED = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [W-1:0]      Bin,
  output logic              Busy,
  output logic              Done,
  output logic [4*NDIG-1:0] Bcd,
  output logic              Neg
);

  localparam int            CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  if (NDIG < ndig_for(W)) begin : g_ndig_check
    $fatal(1, "bcd_seq_conv: NDIG too small to hold 2^W-1");
  end

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        shreg;
  logic [4*NDIG-1:0]   acc;
  logic [4*NDIG-1:0]   adj;
  logic                sign;
  logic                in_neg;
  logic [W-1:0]        mag;

  // Magnitude in W bits: -2^(W-1) maps onto itself, which reads
  // correctly as the unsigned value 2^(W-1).
  assign in_neg = SIGNED && Bin[W-1];
  assign mag    = in_neg ? W'(-Bin) : Bin;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_add3 u_add3 (
      .d (acc[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

  assign Busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (Start) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (cnt == '0) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt   <= '0;
      shreg <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      Bcd   <= '0;
      Neg   <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            shreg <= mag;
            sign  <= in_neg;
            acc   <= '0;
            cnt   <= CNT_TOP;
          end
        end
        ST_SHIFT: begin
          // Adjusted digits and the binary word shift left as one register.
          acc   <= {adj[4*NDIG-2:0], shreg[W-1]};
          shreg <= {shreg[W-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FINISH: begin
          Bcd  <= acc;
          Neg  <= sign;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: unsigned and signed instances
// driven in lockstep, checked against a decimal arithmetic model.
module tb_bcd_seq_conv;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] Bin;

  logic        busy_u, done_u, neg_u;
  logic [39:0] bcd_u;
  logic        busy_s, done_s, neg_s;
  logic [39:0] bcd_s;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  bcd_seq_conv #(.W(32), .NDIG(10), .SIGNED(1'b0)) u_uns (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Bin(Bin),
    .Busy(busy_u), .Done(done_u), .Bcd(bcd_u), .Neg(neg_u)
  );

  bcd_seq_conv #(.W(32), .NDIG(10), .SIGNED(1'b1)) u_sgn (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Bin(Bin),
    .Busy(busy_s), .Done(done_s), .Bcd(bcd_s), .Neg(neg_s)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [39:0] model_bcd(input logic [31:0] v,
                                            input bit sgn);
    longint unsigned m;
    logic [39:0]     r;
    m = (sgn && v[31]) ? (64'd4294967296 - 64'(v)) : 64'(v);
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] v, output int t0);
    Start = 1'b1;
    Bin   = v;
    step();
    Start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(output bit ok, output int busy_n);
    ok     = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_u) begin
        ok = 1'b1;
        break;
      end
      if (busy_u) busy_n++;
      step();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; Bin = '0;
    step(); step();
    Rst = 1'b0;
    n_chk++; if (busy_u !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_u); else n_pass++;
    n_chk++; if (done_u !== 1'b0) $display("FAIL rst_done got %b exp 0", done_u); else n_pass++;
    n_chk++; if (bcd_u !== 40'h0) $display("FAIL rst_bcd got %h exp 0", bcd_u); else n_pass++;
    n_chk++; if (neg_s !== 1'b0) $display("FAIL rst_neg got %b exp 0", neg_s); else n_pass++;
  endtask

  task automatic test_zero();
    int t0, bn;
    bit ok;
    pulse_start(32'd0, t0);
    wait_done(ok, bn);
    n_chk++; if (!ok) $display("FAIL zero_done got timeout exp Done"); else n_pass++;
    n_chk++; if (cyc - t0 !== 33) $display("FAIL zero_lat got %0d exp 33", cyc - t0); else n_pass++;
    n_chk++; if (bn !== 33) $display("FAIL zero_busy got %0d exp 33", bn); else n_pass++;
    n_chk++; if (busy_u !== 1'b0) $display("FAIL zero_busy_at_done got %b exp 0", busy_u); else n_pass++;
    n_chk++; if (bcd_u !== 40'h0) $display("FAIL zero_bcd got %h exp 0", bcd_u); else n_pass++;
    n_chk++; if (neg_u !== 1'b0) $display("FAIL zero_neg got %b exp 0", neg_u); else n_pass++;
    step();
    n_chk++; if (done_u !== 1'b0) $display("FAIL zero_pulse got %b exp 0", done_u); else n_pass++;
  endtask

  task automatic test_convert();
    logic [31:0] vals[$];
    logic [39:0] eu, es;
    int t0, bn;
    bit ok;
    vals.push_back(32'hFFFF_FFFF);
    vals.push_back(-32'd2150);
    vals.push_back(32'h8000_0000);
    for (int i = 0; i < 3; i++) vals.push_back($urandom);
    for (int i = 0; i < 3; i++) vals.push_back($urandom_range(0, 99999));
    for (int i = 0; i < 3; i++) vals.push_back(-$urandom_range(1, 5000));
    foreach (vals[j]) begin
      eu = model_bcd(vals[j], 1'b0);
      es = model_bcd(vals[j], 1'b1);
      pulse_start(vals[j], t0);
      wait_done(ok, bn);
      n_chk++; if (!ok) $display("FAIL conv_done v=%h got timeout", vals[j]); else n_pass++;
      n_chk++; if (bcd_u !== eu) $display("FAIL conv_bcd_u v=%h got %h exp %h", vals[j], bcd_u, eu); else n_pass++;
      n_chk++; if (neg_u !== 1'b0) $display("FAIL conv_neg_u v=%h got %b exp 0", vals[j], neg_u); else n_pass++;
      n_chk++; if (bcd_s !== es) $display("FAIL conv_bcd_s v=%h got %h exp %h", vals[j], bcd_s, es); else n_pass++;
      n_chk++; if (neg_s !== vals[j][31]) $display("FAIL conv_neg_s v=%h got %b exp %b", vals[j], neg_s, vals[j][31]); else n_pass++;
      step();
      n_chk++; if (bcd_u !== eu) $display("FAIL conv_hold v=%h got %h exp %h", vals[j], bcd_u, eu); else n_pass++;
    end
  endtask

  task automatic test_ignore();
    logic [39:0] e;
    int t0, bn, nd;
    bit ok;
    e = model_bcd(32'd101325, 1'b0);
    pulse_start(32'd101325, t0);
    repeat (9) step();
    Start = 1'b1; Bin = 32'd7;
    step();
    Start = 1'b0;
    wait_done(ok, bn);
    n_chk++; if (!ok) $display("FAIL ign_done got timeout"); else n_pass++;
    n_chk++; if (cyc - t0 !== 33) $display("FAIL ign_lat got %0d exp 33", cyc - t0); else n_pass++;
    n_chk++; if (bcd_u !== e) $display("FAIL ign_bcd got %h exp %h", bcd_u, e); else n_pass++;
    nd = 0;
    repeat (40) begin
      step();
      if (done_u) nd++;
    end
    n_chk++; if (nd !== 0) $display("FAIL ign_extra_done got %0d exp 0", nd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [39:0] e;
    int t0, bn, nd;
    bit ok;
    pulse_start(32'd12345, t0);
    repeat (13) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    n_chk++; if (busy_u !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy_u); else n_pass++;
    n_chk++; if (bcd_u !== 40'h0) $display("FAIL rmid_bcd_u got %h exp 0", bcd_u); else n_pass++;
    n_chk++; if (bcd_s !== 40'h0) $display("FAIL rmid_bcd_s got %h exp 0", bcd_s); else n_pass++;
    nd = 0;
    repeat (40) begin
      step();
      if (done_u || busy_u) nd++;
    end
    n_chk++; if (nd !== 0) $display("FAIL rmid_activity got %0d exp 0", nd); else n_pass++;
    e = model_bcd(32'd999, 1'b0);
    pulse_start(32'd999, t0);
    wait_done(ok, bn);
    n_chk++; if (!ok) $display("FAIL rmid_done got timeout"); else n_pass++;
    n_chk++; if (bcd_u !== e) $display("FAIL rmid_bcd got %h exp %h", bcd_u, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1;
    logic [39:0] e1, e2;
    int t0, d0, bn, bad;
    bit ok;
    v1 = $urandom_range(1, 9999999);
    e1 = model_bcd(v1, 1'b0);
    e2 = model_bcd(32'd46273, 1'b0);
    pulse_start(v1, t0);
    wait_done(ok, bn);
    n_chk++; if (bcd_u !== e1) $display("FAIL b2b_first got %h exp %h", bcd_u, e1); else n_pass++;
    d0 = cyc;
    pulse_start(32'd46273, t0);
    ok  = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_u) begin
        ok = 1'b1;
        break;
      end
      if (bcd_u !== e1) bad++;
      step();
    end
    n_chk++; if (!ok) $display("FAIL b2b_done got timeout"); else n_pass++;
    n_chk++; if (cyc - t0 !== 33) $display("FAIL b2b_lat got %0d exp 33", cyc - t0); else n_pass++;
    n_chk++; if (cyc - d0 !== 34) $display("FAIL b2b_period got %0d exp 34", cyc - d0); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL b2b_hold got %0d bad exp 0", bad); else n_pass++;
    n_chk++; if (bcd_u !== e2) $display("FAIL b2b_bcd got %h exp %h", bcd_u, e2); else n_pass++;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Bin = '0;
    test_reset();
    test_zero();
    test_convert();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
